// File: rtl/keyword_nest_checker_pkg.sv
// ---------------------------------------------------------------------------
// keyword_nest_checker_pkg
//   Shared definitions for the keyword nesting checker:
//     - word_state_e : word recogniser states (SPACE, keyword prefixes, IRR)
//     - CH_*         : delimiter and lowercase keyword letters
//     - TYPE_B/F     : block type stored on the nesting stack
//     - err_code_e   : sticky first-error codes
//     - helpers      : next-state function and keyword classification
// ---------------------------------------------------------------------------
package keyword_nest_checker_pkg;

    typedef enum logic [4:0] {
        WS_SPACE,
        WS_B,
        WS_BE,
        WS_BEG,
        WS_BEGI,
        WS_BEGIN,
        WS_E,
        WS_EN,
        WS_END,
        WS_F,
        WS_FO,
        WS_FOR,
        WS_FORK,
        WS_J,
        WS_JO,
        WS_JOI,
        WS_JOIN,
        WS_IRR
    } word_state_e;

    localparam logic [7:0] CH_DELIM = 8'h20;
    // OR-ing this bit folds uppercase letters onto lowercase.
    localparam logic [7:0] CH_CASE  = 8'h20;

    localparam logic [7:0] CH_B = 8'h62;
    localparam logic [7:0] CH_D = 8'h64;
    localparam logic [7:0] CH_E = 8'h65;
    localparam logic [7:0] CH_F = 8'h66;
    localparam logic [7:0] CH_G = 8'h67;
    localparam logic [7:0] CH_I = 8'h69;
    localparam logic [7:0] CH_J = 8'h6A;
    localparam logic [7:0] CH_K = 8'h6B;
    localparam logic [7:0] CH_N = 8'h6E;
    localparam logic [7:0] CH_O = 8'h6F;
    localparam logic [7:0] CH_R = 8'h72;

    localparam logic TYPE_B = 1'b0;
    localparam logic TYPE_F = 1'b1;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_MISMATCH  = 2'd2,
        ERR_OVERFLOW  = 2'd3
    } err_code_e;

    // Word recogniser transition for one accepted byte. The delimiter test
    // uses the raw byte so that 8'h00 (which folds to 8'h20) is not taken as
    // a delimiter. Non-letters can never fold onto a lowercase letter.
    function automatic word_state_e next_word_state(input word_state_e s,
                                                    input logic [7:0]  ch);
        logic [7:0]  lc;
        word_state_e n;
        lc = ch | CH_CASE;
        n  = WS_IRR;
        if (ch == CH_DELIM) begin
            n = WS_SPACE;
        end else begin
            case (s)
                WS_SPACE: begin
                    if      (lc == CH_B) n = WS_B;
                    else if (lc == CH_E) n = WS_E;
                    else if (lc == CH_F) n = WS_F;
                    else if (lc == CH_J) n = WS_J;
                end
                WS_B:    if (lc == CH_E) n = WS_BE;
                WS_BE:   if (lc == CH_G) n = WS_BEG;
                WS_BEG:  if (lc == CH_I) n = WS_BEGI;
                WS_BEGI: if (lc == CH_N) n = WS_BEGIN;
                WS_E:    if (lc == CH_N) n = WS_EN;
                WS_EN:   if (lc == CH_D) n = WS_END;
                WS_F:    if (lc == CH_O) n = WS_FO;
                WS_FO:   if (lc == CH_R) n = WS_FOR;
                WS_FOR:  if (lc == CH_K) n = WS_FORK;
                WS_J:    if (lc == CH_O) n = WS_JO;
                WS_JO:   if (lc == CH_I) n = WS_JOI;
                WS_JOI:  if (lc == CH_N) n = WS_JOIN;
                default: n = WS_IRR;
            endcase
        end
        return n;
    endfunction

    function automatic logic is_opener(input word_state_e s);
        return (s == WS_BEGIN) || (s == WS_FORK);
    endfunction

    function automatic logic is_closer(input word_state_e s);
        return (s == WS_END) || (s == WS_JOIN);
    endfunction

    function automatic logic kw_type(input word_state_e s);
        return ((s == WS_FORK) || (s == WS_JOIN)) ? TYPE_F : TYPE_B;
    endfunction

endpackage

// File: rtl/keyword_nest_checker_nest_stack.sv
// ---------------------------------------------------------------------------
// nest_stack
//   DEPTH x 1-bit LIFO holding the block type of each open nesting level.
//   Ports:
//     clk_i    : clock, rising edge
//     reset_i  : synchronous active-high reset (empties the stack)
//     push_i   : push type_i (ignored when full)
//     pop_i    : pop top entry (ignored when empty; push wins if both)
//     type_i   : type to push (TYPE_B / TYPE_F)
//     top_o    : type of the top entry (TYPE_B when empty)
//     count_o  : number of entries held
//     full_o   : count_o == DEPTH
//     empty_o  : count_o == 0
// ---------------------------------------------------------------------------
module nest_stack
    import keyword_nest_checker_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          type_i,
    output logic          top_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DEPTH-1:0] mem_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage is not reset: a slot is only read after being written.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!reset_i && push_i && !full_o && (CW'(i) == count_q)) begin
                mem_q[i] <= type_i;
            end
        end
    end

    // Top entry lives at index count-1.
    always_comb begin
        top_o = TYPE_B;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == count_q) begin
                top_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/keyword_nest_checker.sv
// ---------------------------------------------------------------------------
// keyword_nest_checker
//   Scans an ASCII byte stream for the keywords begin/end and fork/join
//   (case-insensitive, space-delimited) and checks that they nest properly.
//   Ports:
//     clk        : clock, rising edge
//     reset      : synchronous active-high reset, priority over in_valid
//     in         : input byte
//     in_valid   : byte is consumed on a rising edge only when high
//     result     : stream balanced and error-free, pending word terminated
//     depth      : committed open-block count
//     error      : sticky error flag
//     error_code : first error (0 none, 1 underflow, 2 mismatch, 3 overflow)
//   All outputs derive from registered state only.
// ---------------------------------------------------------------------------
module keyword_nest_checker
    import keyword_nest_checker_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in,
    input  logic                         in_valid,
    output logic                         result,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         error,
    output logic [1:0]                   error_code
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    word_state_e   state_q;
    word_state_e   state_d;
    logic          error_q;
    logic          error_d;
    err_code_e     code_q;
    err_code_e     code_d;

    logic          opener;
    logic          closer;
    logic          word_type;
    logic          commit;
    logic          push;
    logic          pop;
    logic          stk_top;
    logic [CW-1:0] stk_count;
    logic          stk_full;
    logic          stk_empty;
    logic          result_c;

    nest_stack #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_stack (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .type_i  (word_type),
        .top_o   (stk_top),
        .count_o (stk_count),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign opener    = is_opener(state_q);
    assign closer    = is_closer(state_q);
    assign word_type = kw_type(state_q);

    // A keyword commits when the delimiter after it is accepted. Once an
    // error is latched, commits are suppressed so the stack freezes while
    // the word recogniser keeps tracking the stream.
    assign commit = in_valid && (in == CH_DELIM) && !error_q;

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        code_d  = code_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (in_valid) begin
            state_d = next_word_state(state_q, in);
        end

        if (commit && opener) begin
            if (stk_full) begin
                error_d = 1'b1;
                code_d  = ERR_OVERFLOW;
            end else begin
                push = 1'b1;
            end
        end

        if (commit && closer) begin
            if (stk_empty) begin
                error_d = 1'b1;
                code_d  = ERR_UNDERFLOW;
            end else if (stk_top != word_type) begin
                error_d = 1'b1;
                code_d  = ERR_MISMATCH;
            end else begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WS_SPACE;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    // Tentative view: treat a fully spelled pending keyword as if its
    // delimiter had arrived. An opener always leaves depth >= 1; a closer
    // only balances when it matches the top of a one-deep stack.
    always_comb begin
        result_c = 1'b0;
        if (!error_q) begin
            if (opener) begin
                result_c = 1'b0;
            end else if (closer) begin
                result_c = !stk_empty && (stk_top == word_type)
                           && (stk_count == CW'(1));
            end else begin
                result_c = stk_empty;
            end
        end
    end

    assign result     = result_c;
    assign depth      = stk_count;
    assign error      = error_q;
    assign error_code = code_q;

endmodule

// File: doc/keyword_nest_checker.md
KEYWORD_NEST_CHECKER -- requirements
Module: keyword_nest_checker

Interface
REQ-001 Parameter DEPTH, default 16, maximum nesting depth held on the type stack (legal range 2..256).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 Port in  input  8  ASCII character of the input stream.
REQ-005 Port in_valid  input  1  in is consumed on a rising edge only when high; when low, all state holds.
REQ-006 Port result  output  1  high when the stream so far is balanced and error-free, with the pending word treated as terminated.
REQ-007 Port depth  output  $clog2(DEPTH+1)  committed open-block count.
REQ-008 Port error  output  1  sticky error flag.
REQ-009 Port error_code  output  2  first error: 0 none, 1 underflow, 2 mismatch, 3 overflow.

Function
REQ-010 Words are maximal runs of non-delimiter bytes; the delimiter is exactly 8'h20.
REQ-011 Letter comparison is case-insensitive (in | 8'h20 is compared against lowercase); non-letters never match a keyword letter.
REQ-012 Keywords: openers "begin" (type B) and "fork" (type F); closers "end" (type B) and "join" (type F); any other word is irrelevant.
REQ-013 Word FSM states: SPACE, B, BE, BEG, BEGI, BEGIN, E, EN, END, F, FO, FOR, FORK, J, JO, JOI, JOIN, IRR; reset state SPACE.
REQ-014 From SPACE: b->B, e->E, f->F, j->J, delimiter->SPACE, other->IRR; each partial state advances on its next keyword letter, returns to SPACE on delimiter, else goes to IRR.
REQ-015 From BEGIN/END/FORK/JOIN: delimiter -> SPACE and commits the keyword; any other byte -> IRR with no commit; IRR leaves only on delimiter.
REQ-016 Commit of opener: push type onto stack, depth+1; if depth==DEPTH, no push and error code 3.
REQ-017 Commit of closer: if depth==0, error code 1; else if top type differs, error code 2; else pop, depth-1.
REQ-018 error and error_code are sticky: set on the first error only; later errors do not change error_code; stack/depth freeze once error is set.
REQ-019 Tentative view: result = !error && effective depth == 0, where a FSM in BEGIN/FORK adds one and a FSM in END/JOIN subtracts one with a matching top; END/JOIN with depth 0 or a mismatched top forces result low.
REQ-020 result, depth, error, error_code are functions of registered state only; no combinational path from in or in_valid to outputs.
REQ-021 Latency: a byte accepted at edge N is reflected on all outputs after edge N.
REQ-022 A mixed token such as "Begin1" or "endx" is irrelevant; "BEGIN", "End", "fOrK" are keywords.

Reset
REQ-023 On reset: FSM = SPACE, depth = 0, stack contents don't-care, error = 0, error_code = 0, hence result = 1.
REQ-024 Reset takes priority over in_valid and discards any partial word and all errors, including mid-word.

Structure
REQ-025 Shared package holds FSM state encodings, keyword character constants, stack type encodings (B=0, F=1), and error code constants.
REQ-026 A single sub-module nest_stack (DEPTH x 1-bit LIFO with push, pop, top, count, full, empty) is used; the word FSM and error logic live in the top.

Verification
REQ-027 Reset, then "begin end " -> result 0 after 'n' of begin, 1 after 'd', depth 0, error 0.
REQ-028 "fork begin join " -> after join's delimiter, error 1, error_code 2, result 0; subsequent "end end " leaves error_code 2.
REQ-029 "end " from reset -> result 0 after 'd', error_code 1 after the delimiter; "begin" tentative then "s " -> result returns to prior value.
REQ-030 DEPTH=2: "begin fork begin " -> error_code 3 on the third delimiter, depth stays 2.
REQ-031 "BeGiN" with in_valid toggling low between bytes, then " END " -> same result trace as contiguous input, final result 1.
REQ-032 Reset asserted after "begin fo" -> depth 0, result 1, FSM SPACE; "join " next -> error_code 1.
